afifo_wptr_full: RTL and testbench
==================================

AFIFO_WPTR_FULL -- requirements
Module: afifo_wptr_full

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: memory depth in words; power of two, at least 4.
REQ-002 Parameter SYNC_STAGES, default 2: flops in the read-pointer synchronizer; legal range 2..4.
REQ-003 Parameter ALMOST_FULL_THR, default FIFO_DEPTH-2: level at or above which almost-full asserts; legal range 1..FIFO_DEPTH.
REQ-004 Derived constant ADDR_WIDTH = clog2s(FIFO_DEPTH); PTR_WIDTH = ADDR_WIDTH+1.
REQ-005 wr_clk_i  in  1  write-domain clock.
REQ-006 rstn_wr_i  in  1  reset; asynchronous, active-low.
REQ-007 wr_req_i  in  1  upstream write request, one word per cycle.
REQ-008 rd_ptr_gray_i  in  PTR_WIDTH  read pointer in Gray code, from the read-clock domain.
REQ-009 wr_ovf_clr_i  in  1  clears the sticky overflow flag.
REQ-010 wr_en_o  out  1  write strobe to the FIFO memory.
REQ-011 wr_addr_o  out  ADDR_WIDTH  write address to the FIFO memory.
REQ-012 wr_ptr_gray_o  out  PTR_WIDTH  registered Gray write pointer, for the read domain.
REQ-013 wr_full_o  out  1  FIFO full, registered.
REQ-014 wr_almost_full_o  out  1  level >= ALMOST_FULL_THR, registered.
REQ-015 wr_level_o  out  PTR_WIDTH  occupancy as seen from the write domain, registered.
REQ-016 wr_overflow_o  out  1  sticky flag: a write request was rejected.

Function
REQ-017 wr_en_o SHALL equal wr_req_i & ~wr_full_o, combinationally; an accepted write is one where wr_en_o=1.
REQ-018 The binary pointer wbin (PTR_WIDTH bits) SHALL increment by 1 on each accepted write and wrap modulo 2*FIFO_DEPTH.
- wr_addr_o = wbin[ADDR_WIDTH-1:0].
- wr_ptr_gray_o SHALL be registered at (wbin_next>>1)^wbin_next on the same edge as the increment.
REQ-019 rd_ptr_gray_i SHALL pass through SYNC_STAGES flops before use (rgray_s); no other logic may consume it.
REQ-020 wr_full_o SHALL register as (gray(wbin_next) == {~rgray_s[MSB:MSB-1], rgray_s[MSB-2:0]}).
- Full SHALL assert on the edge of the write that fills the FIFO.
- No write is accepted while full.
REQ-021 Full SHALL deassert no earlier than SYNC_STAGES+1 cycles after rd_ptr_gray_i changes; this pessimism is required.
REQ-022 wr_level_o SHALL register wbin_next - gray2bin(rgray_s), modulo 2^PTR_WIDTH; its range is 0..FIFO_DEPTH.
REQ-023 wr_almost_full_o SHALL register (wr_level_next >= ALMOST_FULL_THR).
REQ-024 wr_overflow_o SHALL set on any cycle with wr_req_i & wr_full_o.
- wr_ovf_clr_i SHALL clear it.
- Set has priority over clear in the same cycle.
REQ-025 When a write and a read-pointer update occur in the same cycle, the write SHALL take effect and the flags SHALL reflect both.

Reset
REQ-026 rstn_wr_i low SHALL asynchronously clear wbin, wr_ptr_gray_o, all synchronizer flops, wr_full_o, wr_almost_full_o, wr_level_o and wr_overflow_o to 0.
REQ-027 Reset mid-burst SHALL discard in-flight writes; the FIFO SHALL appear empty, and the read side is reset jointly by the system.

Configuration
REQ-028 Macro AFIFO_WR_LEVEL_EN.
- Defined: wr_level_o and wr_almost_full_o SHALL behave as in REQ-022 and REQ-023.
- Undefined: both SHALL be tied to 0, and the Gray-to-binary conversion and subtractor SHALL be absent.
- Full and overflow behaviour SHALL be identical either way.

Structure
REQ-029 The shared package/header SHALL hold clog2s, bin2gray and gray2bin; the read-side block shares it.
REQ-030 The synchronizer SHALL be the sub-module afifo_sync (params WIDTH, STAGES; async active-low reset), reused by the read side.

Verification
REQ-031 FIFO_DEPTH=16, SYNC_STAGES=2, ALMOST_FULL_THR=14, rd_ptr_gray_i=0, 16 back-to-back wr_req_i:
- wr_addr_o runs 0..15.
- wr_almost_full_o rises the edge after write 14.
- wr_full_o rises the edge after write 16.
REQ-032 While full, 3 further wr_req_i cycles:
- wr_en_o stays 0, wbin stays unchanged.
- wr_overflow_o = 1 and remains 1 until wr_ovf_clr_i.
REQ-033 From full, step rd_ptr_gray_i to gray(1)=5'b00001:
- wr_full_o falls exactly 3 cycles later.
- wr_level_o = 15.
REQ-034 Run 40 writes with the read pointer tracking 2 behind:
- wr_addr_o wraps 15→0 and the MSB of wbin toggles.
- Full is never falsely asserted.
REQ-035 Assert rstn_wr_i low mid-burst at wbin=7: all outputs are 0 immediately; the next write uses address 0.
REQ-036 Build without AFIFO_WR_LEVEL_EN and rerun REQ-031: full timing is identical; wr_level_o and wr_almost_full_o stay 0.

Source files
------------

// File: rtl/afifo_wptr_full_pkg.sv
// rtl/afifo_wptr_full_pkg.sv - shared async-FIFO helpers for the write and read pointer blocks
package afifo_wptr_full_pkg;

  function automatic int clog2s(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of a narrower pointer are zero-extended, so the 32-bit prefix XOR stays correct.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_sync.sv
// rtl/afifo_sync.sv - multi-flop synchronizer with async active-low reset, shared by both FIFO pointer blocks
module afifo_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/afifo_wptr_full.sv
// rtl/afifo_wptr_full.sv - async FIFO write pointer, full/overflow flags; AFIFO_WR_LEVEL_EN adds level and almost-full
module afifo_wptr_full
  import afifo_wptr_full_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_FULL_THR = FIFO_DEPTH - 2,
  localparam int ADDR_WIDTH     = clog2s(FIFO_DEPTH),
  localparam int PTR_WIDTH      = ADDR_WIDTH + 1
) (
  input  logic                  wr_clk_i,
  input  logic                  rstn_wr_i,
  input  logic                  wr_req_i,
  input  logic [PTR_WIDTH-1:0]  rd_ptr_gray_i,
  input  logic                  wr_ovf_clr_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [PTR_WIDTH-1:0]  wr_ptr_gray_o,
  output logic                  wr_full_o,
  output logic                  wr_almost_full_o,
  output logic [PTR_WIDTH-1:0]  wr_level_o,
  output logic                  wr_overflow_o
);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("afifo_wptr_full: FIFO_DEPTH must be a power of two >= 4");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
    $error("afifo_wptr_full: SYNC_STAGES must be 2..4");
  end
  if ((ALMOST_FULL_THR < 1) || (ALMOST_FULL_THR > FIFO_DEPTH)) begin : g_bad_thr
    $error("afifo_wptr_full: ALMOST_FULL_THR must be 1..FIFO_DEPTH");
  end

  logic [PTR_WIDTH-1:0] wbin;
  logic [PTR_WIDTH-1:0] wbin_next;
  logic [PTR_WIDTH-1:0] wgray_next;
  logic [PTR_WIDTH-1:0] rgray_s;
  logic [PTR_WIDTH-1:0] full_cmp;

  afifo_sync #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i  (wr_clk_i),
    .rstn_i (rstn_wr_i),
    .d_i    (rd_ptr_gray_i),
    .q_o    (rgray_s)
  );

  assign wr_en_o    = wr_req_i & ~wr_full_o;
  assign wr_addr_o  = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + PTR_WIDTH'(wr_en_o);
  assign wgray_next = PTR_WIDTH'(bin2gray(32'(wbin_next)));
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
  assign full_cmp   = {~rgray_s[PTR_WIDTH-1:PTR_WIDTH-2], rgray_s[PTR_WIDTH-3:0]};

  always_ff @(posedge wr_clk_i or negedge rstn_wr_i) begin
    if (!rstn_wr_i) begin
      wbin          <= '0;
      wr_ptr_gray_o <= '0;
      wr_full_o     <= 1'b0;
      wr_overflow_o <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      wr_ptr_gray_o <= wgray_next;
      wr_full_o     <= (wgray_next == full_cmp);
      if (wr_req_i && wr_full_o) begin
        wr_overflow_o <= 1'b1;
      end else if (wr_ovf_clr_i) begin
        wr_overflow_o <= 1'b0;
      end
    end
  end

`ifdef AFIFO_WR_LEVEL_EN
  localparam logic [PTR_WIDTH-1:0] AF_THR = PTR_WIDTH'(ALMOST_FULL_THR);

  logic [PTR_WIDTH-1:0] rbin_s;
  logic [PTR_WIDTH-1:0] level_next;

  assign rbin_s     = PTR_WIDTH'(gray2bin(32'(rgray_s)));
  assign level_next = wbin_next - rbin_s;

  always_ff @(posedge wr_clk_i or negedge rstn_wr_i) begin
    if (!rstn_wr_i) begin
      wr_level_o       <= '0;
      wr_almost_full_o <= 1'b0;
    end else begin
      wr_level_o       <= level_next;
      wr_almost_full_o <= (level_next >= AF_THR);
    end
  end
`else
  assign wr_level_o       = '0;
  assign wr_almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_wptr_full.sv
// tb/tb_afifo_wptr_full.sv - directed vector bench for afifo_wptr_full (depth 16, 2 sync stages)
module tb_afifo_wptr_full;

`ifdef AFIFO_WR_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_req = 1'b0;
  logic [4:0] rd_gray = '0;
  logic       ovf_clr = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic       wr_full;
  logic       wr_af;
  logic [4:0] wr_level;
  logic       wr_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  afifo_wptr_full #(
    .FIFO_DEPTH      (16),
    .SYNC_STAGES     (2),
    .ALMOST_FULL_THR (14)
  ) dut (
    .wr_clk_i         (clk),
    .rstn_wr_i        (rstn),
    .wr_req_i         (wr_req),
    .rd_ptr_gray_i    (rd_gray),
    .wr_ovf_clr_i     (ovf_clr),
    .wr_en_o          (wr_en),
    .wr_addr_o        (wr_addr),
    .wr_ptr_gray_o    (wr_gray),
    .wr_full_o        (wr_full),
    .wr_almost_full_o (wr_af),
    .wr_level_o       (wr_level),
    .wr_overflow_o    (wr_ovf)
  );

  typedef struct {
    logic       req;
    logic [4:0] rd;
    logic       clr;
    logic       en;
    logic [3:0] addr;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
    logic [4:0] gray;
  } vec_t;

  vec_t vecs [25];

  function automatic logic [4:0] gr(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic req, input logic [4:0] rd, input logic clr,
                              input logic en, input logic [3:0] addr, input logic full,
                              input logic [4:0] lvl, input logic ovf, input logic [4:0] wb);
    vec_t v;
    v.req  = req;
    v.rd   = rd;
    v.clr  = clr;
    v.en   = en;
    v.addr = addr;
    v.full = full;
    v.af   = LVL_EN && (lvl >= 5'd14);
    v.lvl  = LVL_EN ? lvl : 5'd0;
    v.ovf  = ovf;
    v.gray = gr(wb);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_req  = 1'b0;
    rd_gray = '0;
    ovf_clr = 1'b0;
    rstn    = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i] = mk(1'b1, 5'd0, 1'b0, 1'b1, 4'(i), (i == 15), 5'(i + 1), 1'b0, 5'(i + 1));
    end
    vecs[16] = mk(1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd16, 1'b1, 5'd16);
    vecs[17] = mk(1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd16, 1'b1, 5'd16);
    vecs[18] = mk(1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 1'b1, 5'd16, 1'b1, 5'd16);
    vecs[19] = mk(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd16, 1'b1, 5'd16);
    vecs[20] = mk(1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b1, 5'd16, 1'b0, 5'd16);
    vecs[21] = mk(1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 1'b1, 5'd16, 1'b0, 5'd16);
    vecs[22] = mk(1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 1'b1, 5'd16, 1'b0, 5'd16);
    vecs[23] = mk(1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 1'b0, 5'd15, 1'b0, 5'd16);
    vecs[24] = mk(1'b1, 5'd1, 1'b0, 1'b1, 4'd0, 1'b1, 5'd16, 1'b0, 5'd17);

    #2;
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_gray", 32'(wr_gray), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_ovf", 32'(wr_ovf), 32'd0);
    chk("rst_level", 32'(wr_level), 32'd0);
    chk("rst_af", 32'(wr_af), 32'd0);
    do_reset();

    // Fill, overflow with set-over-clear, clear, read-pointer step, refill.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      wr_req  = vecs[i].req;
      rd_gray = vecs[i].rd;
      ovf_clr = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_en", i), 32'(wr_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_full", i), 32'(wr_full), 32'(vecs[i].full));
      chk($sformatf("v%0d_af", i), 32'(wr_af), 32'(vecs[i].af));
      chk($sformatf("v%0d_level", i), 32'(wr_level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_ovf", i), 32'(wr_ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_gray", i), 32'(wr_gray), 32'(vecs[i].gray));
    end

    // 40 writes with the read pointer trailing by two: wraps twice past address 15, never full.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      wr_req  = 1'b1;
      rd_gray = gr((k >= 2) ? 5'(k - 2) : 5'd0);
      #1;
      chk($sformatf("wrap%0d_en", k), 32'(wr_en), 32'd1);
      chk($sformatf("wrap%0d_addr", k), 32'(wr_addr), 32'(k % 16));
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_full", k), 32'(wr_full), 32'd0);
      chk($sformatf("wrap%0d_gray", k), 32'(wr_gray), 32'(gr(5'(k + 1))));
    end

    // Reset asserted mid-burst at wbin=7.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      wr_req = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("pre_rst_addr", 32'(wr_addr), 32'd7);
    #2;
    wr_req = 1'b0;
    rstn   = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_gray", 32'(wr_gray), 32'd0);
    chk("mid_rst_full", 32'(wr_full), 32'd0);
    chk("mid_rst_af", 32'(wr_af), 32'd0);
    chk("mid_rst_level", 32'(wr_level), 32'd0);
    chk("mid_rst_ovf", 32'(wr_ovf), 32'd0);
    chk("mid_rst_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    wr_req = 1'b1;
    #1;
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_en", 32'(wr_en), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_gray", 32'(wr_gray), 32'(gr(5'd1)));
    @(negedge clk);
    wr_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
